fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It holds the PC and issues word-aligned requests to instruction memory over a valid/ready request channel. It accepts in-order responses and buffers each {pc, instr} pair in a small FIFO. It presents them to decode over a valid/ready channel, and handles redirects from branch/jump resolution by flushing the buffer and dropping stale in-flight responses.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, imem request/response tracking, output FIFO.
// Define FETCH_PERF_CNT_EN to enable the delivered-instruction counter.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  typedef enum logic {BOOT, RUN} fetch_st_e;
endpackage

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_count
);
  import fetch_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FIFO_DEPTH);

  fetch_st_e state_q, state_d;

  logic [31:0]   pc_q;
  logic [CW-1:0] outst_q, kill_q, cnt_q;
  logic [CW-1:0] outst_d, kill_d, cnt_d;
  logic [AW-1:0] wr_q, rd_q, pq_wr_q, pq_rd_q;

  fetch_ent_t  fifo_mem [FIFO_DEPTH];
  logic [31:0] pq_mem   [FIFO_DEPTH];
  fetch_ent_t  head;

  logic          req_v;
  logic          req_hs;
  logic          pop;
  logic          push;
  logic          rsp_kill;
  logic          rsp_keep;
  logic [CW+1:0] credit;
  logic [1:0]    unused_redir_lsb;

  assign unused_redir_lsb = redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Credits count every slot a request may still claim in the FIFO
  assign credit = {2'b00, outst_q}
                + {2'b00, kill_q}
                + {2'b00, cnt_q};

  always_comb begin
    state_d = state_q;
    req_v   = 1'b0;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     req_v   = credit < DEPTH_W;
      default: state_d = BOOT;
    endcase
  end

  assign imem_req_valid = req_v;
  assign imem_req_addr  = pc_q;

  assign req_hs   = req_v && imem_req_ready;
  assign out_valid = cnt_q != '0;
  assign pop      = out_valid && out_ready;
  assign rsp_kill = imem_rsp_valid && (kill_q != '0);
  assign rsp_keep = imem_rsp_valid && (kill_q == '0);
  assign push     = rsp_keep && !redirect_valid;

  always_comb begin
    outst_d = outst_q + CW'(req_hs) - CW'(rsp_keep);
    kill_d  = kill_q - CW'(rsp_kill);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      kill_d  = kill_d + outst_d;
      outst_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      kill_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
    end else begin
      outst_q <= outst_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      if (redirect_valid)
        pc_q <= {redirect_pc[31:2], 2'b00};
      else if (req_hs)
        pc_q <= pc_q + 32'd4;
      if (req_hs)
        pq_wr_q <= pq_wr_q + AW'(1);
      if (imem_rsp_valid)
        pq_rd_q <= pq_rd_q + AW'(1);
      if (redirect_valid) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; validity is tracked by the counters
  always_ff @(posedge clk) begin
    if (req_hs)
      pq_mem[pq_wr_q] <= pc_q;
    if (push)
      fifo_mem[wr_q] <= '{pc: pq_mem[pq_rd_q], instr: imem_rsp_data};
  end

  assign head      = out_valid ? fifo_mem[rd_q] : '0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   perf_q <= '0;
    else if (pop) perf_q <= perf_q + 32'd1;
  end

  assign fetch_count = perf_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order latency-configurable memory.
// Expects fetch_count to track deliveries only when FETCH_PERF_CNT_EN is set.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] PERF_N = 32'd10;
`else
  localparam logic [31:0] PERF_N = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: in order, fixed latency, no backpressure
  logic [31:0] mq_a[$];
  int          mq_d[$];
  logic [31:0] req_log[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq_a.delete();
      mq_d.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_a.push_back(imem_req_addr);
        mq_d.push_back(cyc + lat);
        req_log.push_back(imem_req_addr);
      end
      #1;
      if (mq_d.size() > 0 && mq_d[0] <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = f(mq_a.pop_front());
        void'(mq_d.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  logic [31:0] opc[$];
  logic [31:0] oins[$];
  int          ocyc[$];
  int          mcyc = 0;

  always @(posedge clk) begin
    mcyc++;
    if (rst_n && out_valid && out_ready) begin
      opc.push_back(out_pc);
      oins.push_back(out_instr);
      ocyc.push_back(mcyc);
    end
  end

  function automatic logic [31:0] get_pc(input int i);
    return (i < opc.size()) ? opc[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_ins(input int i);
    return (i < oins.size()) ? oins[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int ob;
    int rb;
    int n40;
    rst_n = 1'b0;
    out_ready = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // reset state
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_fetch_count", fetch_count, 0);
    chk("rst_req_addr", imem_req_addr, 0);

    // 1: boot cycle, latency, steady stream
    rst_n = 1'b1;
    #1;
    chk("t1_boot_noreq", 32'(imem_req_valid), 0);
    ob = opc.size();
    tick(1);
    chk("t1_req_valid", 32'(imem_req_valid), 1);
    chk("t1_req_addr0", imem_req_addr, 32'h0);
    chk("t1_no_out", 32'(out_valid), 0);
    tick(1);
    chk("t1_req_addr4", imem_req_addr, 32'h4);
    chk("t1_no_out2", 32'(out_valid), 0);
    tick(1);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_pc", out_pc, 32'h0);
    chk("t1_out_instr", out_instr, f(32'h0));
    tick(10);
    for (int i = 0; i < 8; i++) begin
      chk("t1_seq_pc", get_pc(ob + i), 32'(4 * i));
      chk("t1_seq_ins", get_ins(ob + i), f(32'(4 * i)));
    end
    chk("t1_rate", 32'((ocyc.size() > ob + 7) ?
        ocyc[ob + 7] - ocyc[ob] : -1), 32'd7);

    // 2: backpressure stops issue at the credit limit
    out_ready = 1'b0;
    lat = 1;
    do_reset();
    rb = req_log.size();
    ob = opc.size();
    tick(12);
    chk("t2_req_cnt", 32'(req_log.size() - rb), 32'd4);
    chk("t2_last_addr",
        (req_log.size() > rb + 3) ? req_log[rb + 3] : 32'hFFFF_FFFF,
        32'hC);
    chk("t2_req_stop", 32'(imem_req_valid), 0);
    chk("t2_hold_v", 32'(out_valid), 1);
    chk("t2_hold_pc", out_pc, 32'h0);
    chk("t2_hold_ins", out_instr, f(32'h0));
    tick(1);
    chk("t2_hold_pc2", out_pc, 32'h0);
    out_ready = 1'b1;
    tick(8);
    for (int i = 0; i < 6; i++)
      chk("t2_resume_pc", get_pc(ob + i), 32'(4 * i));

    // 3: redirect with two stale responses in flight
    lat = 3;
    do_reset();
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    imem_req_ready = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("t3_req_valid", 32'(imem_req_valid), 1);
    chk("t3_req_addr", imem_req_addr, 32'h100);
    ob = opc.size();
    tick(10);
    chk("t3_pc0", get_pc(ob), 32'h100);
    chk("t3_ins0", get_ins(ob), f(32'h100));
    chk("t3_pc1", get_pc(ob + 1), 32'h104);
    chk("t3_pc2", get_pc(ob + 2), 32'h108);

    // 4: redirect coincides with request and response
    lat = 1;
    do_reset();
    tick(5);
    chk("t4_req_hs", 32'(imem_req_valid), 1);
    chk("t4_req_addr", imem_req_addr, 32'h10);
    chk("t4_head_pc", out_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    chk("t4_flush", 32'(out_valid), 0);
    chk("t4_new_addr", imem_req_addr, 32'h200);
    ob = opc.size();
    tick(1);
    chk("t4_killed", 32'(out_valid), 0);
    tick(6);
    chk("t4_pc0", get_pc(ob), 32'h200);
    chk("t4_pc1", get_pc(ob + 1), 32'h204);
    chk("t4_pc2", get_pc(ob + 2), 32'h208);

    // 5: back-to-back redirects
    do_reset();
    tick(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick(1);
    redirect_pc = 32'h80;
    ob = opc.size();
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    chk("t5_pc0", get_pc(ob), 32'h80);
    chk("t5_pc1", get_pc(ob + 1), 32'h84);
    chk("t5_pc2", get_pc(ob + 2), 32'h88);
    n40 = 0;
    for (int i = ob; i < opc.size(); i++)
      if (opc[i] == 32'h40) n40++;
    chk("t5_no_0x40", 32'(n40), 0);

    // 6: delivery counter, redirect, then reset mid-stream
    out_ready = 1'b1;
    do_reset();
    ob = opc.size();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (opc.size() - ob >= 10) begin
        out_ready = 1'b0;
        break;
      end
    end
    chk("t6_delivered", 32'(opc.size() - ob), 32'd10);
    chk("t6_count", fetch_count, PERF_N);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    chk("t6_count_redir", fetch_count, PERF_N);
    out_ready = 1'b1;
    tick(4);
    chk("t6_busy", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 0);
    chk("t6_rst_out_pc", out_pc, 0);
    chk("t6_rst_out_instr", out_instr, 0);
    chk("t6_rst_count", fetch_count, 0);
    chk("t6_rst_addr", imem_req_addr, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
